// File: rtl/face_cmd_decoder.sv
// Instruction front-end for the Frodo acceleration engine.
// Decodes 32-bit custom instructions into the base-address, matrix-size and mode
// registers, then launches one core computation and tracks it to completion.
module face_cmd_decoder #(
  parameter logic [5:0]  OPCODE   = 6'b010101,
  parameter int unsigned NUM_BASE = 3,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SIZE_W   = 16,
  parameter int unsigned SIZE_RST = 640,
  parameter int unsigned CNT_W    = 24
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  instr,
  input  logic                         instr_valid,
  output logic                         instr_ready,
  output logic [NUM_BASE*ADDR_W-1:0]   base_addr,
  output logic [SIZE_W-1:0]            matrix_size,
  output logic [2:0]                   mem_mode,
  output logic [1:0]                   addr_mode,
  output logic                         calc_init,
  input  logic                         calc_done,
  output logic                         busy,
  output logic                         calc_finish,
  output logic                         illegal_instr,
  output logic [CNT_W-1:0]             calc_cycles
);

  localparam int unsigned IMM_W      = 21;
  localparam int unsigned BASE_BUS_W = NUM_BASE * ADDR_W;
  // Bits of a base register owned by SET_LO; SET_HI writes everything above.
  localparam logic [ADDR_W-1:0] LO_MASK = ADDR_W'({IMM_W{1'b1}});

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] FUNC_SET_LO   = 2'd0;
  localparam logic [1:0] FUNC_SET_HI   = 2'd1;
  localparam logic [1:0] FUNC_SET_SIZE = 2'd2;
  localparam logic [1:0] FUNC_CALC     = 2'd3;

  state_t state, state_next;

  logic [5:0]       opcode;
  logic [1:0]       func;
  logic [2:0]       sel;
  logic [IMM_W-1:0] imm;
  logic             accept;

  logic [BASE_BUS_W-1:0] base_next;
  logic [SIZE_W-1:0]     size_next;
  logic [2:0]            mem_mode_next;
  logic [1:0]            addr_mode_next;
  logic                  calc_init_next;
  logic                  busy_next;
  logic                  calc_finish_next;
  logic                  illegal_next;
  logic [CNT_W-1:0]      cycles_next;

  assign opcode = instr[31:26];
  assign func   = instr[25:24];
  assign sel    = instr[23:21];
  assign imm    = instr[20:0];

  // Instructions are only taken while idle and out of reset.
  assign instr_ready = (state == IDLE) && !rst;
  assign accept      = instr_valid && instr_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state, decode and next values of every registered output.
  always_comb begin
    state_next       = state;
    base_next        = base_addr;
    size_next        = matrix_size;
    mem_mode_next    = mem_mode;
    addr_mode_next   = addr_mode;
    calc_init_next   = 1'b0;
    busy_next        = 1'b0;
    calc_finish_next = 1'b0;
    illegal_next     = 1'b0;
    cycles_next      = calc_cycles;

    case (state)
      IDLE: begin
        if (accept) begin
          if (opcode != OPCODE) begin
            illegal_next = 1'b1;
          end else begin
            case (func)
              FUNC_SET_LO, FUNC_SET_HI: begin
                if (32'(sel) >= NUM_BASE) begin
                  illegal_next = 1'b1;
                end else begin
                  for (int unsigned k = 0; k < NUM_BASE; k++) begin
                    if (sel == 3'(k)) begin
                      if (func == FUNC_SET_LO) begin
                        base_next[k*ADDR_W +: ADDR_W] = ADDR_W'(imm);
                      end else begin
                        // Shifting imm up by 21 leaves only imm[ADDR_W-22:0];
                        // with ADDR_W==21 nothing survives and the write is a no-op.
                        base_next[k*ADDR_W +: ADDR_W] =
                          (base_addr[k*ADDR_W +: ADDR_W] & LO_MASK) |
                          ADDR_W'({imm, {IMM_W{1'b0}}});
                      end
                    end
                  end
                end
              end
              FUNC_SET_SIZE: begin
                if (imm == '0) illegal_next = 1'b1;
                else           size_next    = SIZE_W'(imm);
              end
              default: begin
                mem_mode_next  = imm[2:0];
                addr_mode_next = imm[4:3];
                cycles_next    = '0;
                calc_init_next = 1'b1;
                busy_next      = 1'b1;
                state_next     = ISSUE;
              end
            endcase
          end
        end
      end
      ISSUE: begin
        if (calc_done) begin
          calc_finish_next = 1'b1;
          state_next       = DONE;
        end else begin
          busy_next  = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (calc_cycles != '1) cycles_next = calc_cycles + CNT_W'(1);
        if (calc_done) begin
          calc_finish_next = 1'b1;
          state_next       = DONE;
        end else begin
          busy_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output and configuration registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_addr     <= '0;
      matrix_size   <= SIZE_W'(SIZE_RST);
      mem_mode      <= '0;
      addr_mode     <= '0;
      calc_init     <= 1'b0;
      busy          <= 1'b0;
      calc_finish   <= 1'b0;
      illegal_instr <= 1'b0;
      calc_cycles   <= '0;
    end else begin
      base_addr     <= base_next;
      matrix_size   <= size_next;
      mem_mode      <= mem_mode_next;
      addr_mode     <= addr_mode_next;
      calc_init     <= calc_init_next;
      busy          <= busy_next;
      calc_finish   <= calc_finish_next;
      illegal_instr <= illegal_next;
      calc_cycles   <= cycles_next;
    end
  end

endmodule
